// File: rtl/cpu_trace_buffer.sv
// Retire-trace capture FIFO: first-word-fall-through, drop counter, freeze control.
// Optional NOP filtering is enabled by defining TRACE_NOP_FILTER_EN.
module cpu_trace_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_valid,
    input  logic [XLEN-1:0]            trace_pc,
    input  logic [31:0]                trace_instr,
    input  logic [XLEN-1:0]            trace_result,
    input  logic                       freeze,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_instr,
    output logic [XLEN-1:0]            rd_result,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] pc_mem     [DEPTH];
    logic [31:0]     instr_mem  [DEPTH];
    logic [XLEN-1:0] result_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   drop_q;

    logic accept;
    logic capture;
    logic push;
    logic pop;
    logic drop;

`ifdef TRACE_NOP_FILTER_EN
    assign accept = (trace_instr != 32'h0000_0013);
`else
    assign accept = 1'b1;
`endif

    assign capture = trace_valid && !freeze && accept;
    assign pop     = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign count    = count_q;
    assign drop_count = drop_q;

    assign rd_pc     = empty ? '0 : pc_mem[rd_ptr_q];
    assign rd_instr  = empty ? '0 : instr_mem[rd_ptr_q];
    assign rd_result = empty ? '0 : result_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr_q]     <= trace_pc;
            instr_mem[wr_ptr_q]  <= trace_instr;
            result_mem[wr_ptr_q] <= trace_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer; a transaction-level model feeds a
// scoreboard queue that is checked whenever a record is popped.
module tb_cpu_trace_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] res;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic [31:0] trace_result;
    logic        freeze;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [31:0] rd_result;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] drop_count;

    rec_t sb[$];
    int   mcount = 0;
    int   mdrop  = 0;
    int   tests  = 0;
    int   fails  = 0;

    cpu_trace_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_instr  (trace_instr),
        .trace_result (trace_result),
        .freeze       (freeze),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_pc        (rd_pc),
        .rd_instr     (rd_instr),
        .rd_result    (rd_result),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(count), 64'(mcount));
        chk("full", 64'(full), 64'(mcount == DEPTH));
        chk("empty", 64'(empty), 64'(mcount == 0));
        chk("rd_valid", 64'(rd_valid), 64'(mcount != 0));
        chk("drop_count", 64'(drop_count), 64'(mdrop));
        if (sb.size() > 0) begin
            chk("head_pc", 64'(rd_pc), 64'(sb[0].pc));
            chk("head_instr", 64'(rd_instr), 64'(sb[0].instr));
            chk("head_result", 64'(rd_result), 64'(sb[0].res));
        end else begin
            chk("empty_pc", 64'(rd_pc), 64'd0);
            chk("empty_instr", 64'(rd_instr), 64'd0);
            chk("empty_result", 64'(rd_result), 64'd0);
        end
    endtask

    // One clock: check any popped record, update the model, advance past the edge.
    task automatic cycle();
        bit   acc;
        bit   mpop;
        bit   cap;
        bit   mpush;
        rec_t r;
        rec_t e;
        #1;
`ifdef TRACE_NOP_FILTER_EN
        acc = (trace_instr != 32'h0000_0013);
`else
        acc = 1'b1;
`endif
        if (rst) begin
            sb.delete();
            mcount = 0;
            mdrop  = 0;
        end else begin
            mpop  = rd_ready && (mcount > 0);
            cap   = trace_valid && !freeze && acc;
            mpush = cap && ((mcount < DEPTH) || mpop);
            if (mpop) begin
                e = sb.pop_front();
                chk("pop_valid", 64'(rd_valid), 64'd1);
                chk("pop_pc", 64'(rd_pc), 64'(e.pc));
                chk("pop_instr", 64'(rd_instr), 64'(e.instr));
                chk("pop_result", 64'(rd_result), 64'(e.res));
                mcount--;
            end
            if (mpush) begin
                r.pc    = trace_pc;
                r.instr = trace_instr;
                r.res   = trace_result;
                sb.push_back(r);
                mcount++;
            end
            if (cap && !mpush && mdrop < 65535) mdrop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] res);
        trace_valid  = v;
        trace_pc     = pc;
        trace_instr  = ins;
        trace_result = res;
    endtask

    initial begin
        rst = 1'b1;
        freeze = 1'b0;
        rd_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h0010_0093, 32'h5);

        // Reset held two cycles with trace_valid high
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check_state();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);

        // Single record, visible the cycle after its push
        drive(1'b1, 32'h4, 32'h0010_0093, 32'h1);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check_state();
        chk("single_rd_pc", 64'(rd_pc), 64'h4);
        chk("single_count", 64'(count), 64'd1);
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        check_state();

        // Fill with 20 records: 16 stored, 4 dropped
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 32'(i * 3));
            cycle();
            check_state();
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_drop", 64'(drop_count), 64'd4);

        // Drain: scoreboard expects pc 0..60 in order
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_pc", 64'(rd_pc), 64'(i * 4));
            cycle();
        end
        rd_ready = 1'b0;
        check_state();

        // Refill, then push and pop together while full across the pointer wrap
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h2000_0000 + 32'(i), 32'(i));
            cycle();
        end
        check_state();
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), 32'h3000_0000 + 32'(i), 32'(i + 7));
            cycle();
            check_state();
            chk("fullsim_count", 64'(count), 64'd16);
            chk("fullsim_drop", 64'(drop_count), 64'd4);
        end

        // Freeze: nothing stored or dropped, pops still drain
        freeze = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 32'h4000_0000, 32'h0);
            cycle();
            check_state();
        end
        chk("freeze_drop", 64'(drop_count), 64'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_state();
        end
        chk("freeze_drain_count", 64'(count), 64'd11);
        freeze = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 11; i++) cycle();
        rd_ready = 1'b0;
        check_state();

        // NOP filter behaviour
        drive(1'b1, 32'h800, 32'h0000_0013, 32'h0);
        cycle();
        drive(1'b1, 32'h804, 32'h0020_0113, 32'h2);
        cycle();
        drive(1'b1, 32'h808, 32'h0000_0013, 32'h0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check_state();
`ifdef TRACE_NOP_FILTER_EN
        chk("filter_count", 64'(count), 64'd1);
        chk("filter_instr", 64'(rd_instr), 64'h0020_0113);
`else
        chk("nofilter_count", 64'(count), 64'd3);
        chk("nofilter_instr", 64'(rd_instr), 64'h0000_0013);
`endif

        // Mid-operation reset discards everything, including a concurrent push/pop
        rst = 1'b1;
        rd_ready = 1'b1;
        drive(1'b1, 32'h900, 32'h0010_0093, 32'h9);
        cycle();
        rst = 1'b0;
        rd_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check_state();
        chk("midreset_empty", 64'(empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the width of the PC and result fields.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of trace entries; the value SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port trace_valid, input, 1 bit, meaning a retire record is presented this cycle.
REQ-006 The block SHALL have ports trace_pc (input, XLEN bits), trace_instr (input, 32 bits) and trace_result (input, XLEN bits), carrying the retired PC, instruction word and ALU result.
REQ-007 The block SHALL have port freeze, input, 1 bit; while it is high, capture is halted.
REQ-008 The block SHALL have ports rd_valid (output, 1 bit) and rd_ready (input, 1 bit), forming the read-side handshake.
REQ-009 The block SHALL have ports rd_pc (output, XLEN bits), rd_instr (output, 32 bits) and rd_result (output, XLEN bits), presenting the head record.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, meaning the number of stored entries.
REQ-011 The block SHALL have ports full and empty, outputs, 1 bit each.
REQ-012 The block SHALL have port drop_count, output, 16 bits, meaning the number of records lost.

Function
REQ-013 push SHALL equal trace_valid && !freeze && accept && (!full || pop), where accept is 1 unless excluded by REQ-030.
REQ-014 pop SHALL equal rd_valid && rd_ready.
REQ-015 A pushed record SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-016 On pop, rd_ptr SHALL increment modulo DEPTH.
REQ-017 On push without pop, count SHALL increment; on pop without push, count SHALL decrement; on both or neither, count SHALL be unchanged.
REQ-018 The buffer SHALL be first-word-fall-through: a record pushed at edge N SHALL appear on rd_* with rd_valid=1 in the cycle after edge N when the buffer was empty.
REQ-019 rd_valid SHALL equal !empty.
REQ-020 rd_pc, rd_instr and rd_result SHALL read 0 while empty.
REQ-021 full SHALL equal (count==DEPTH), and empty SHALL equal (count==0).
REQ-022 When full, a simultaneous push and pop SHALL be accepted, and count SHALL remain DEPTH.
REQ-023 A drop SHALL be a cycle with trace_valid && !freeze && accept && full && !pop; in that cycle drop_count SHALL increment, saturating at 16'hFFFF, and the buffer contents SHALL be unchanged.
REQ-024 Records presented while freeze=1 SHALL be neither stored nor counted as drops.
REQ-025 Pop SHALL remain permitted while freeze=1.
REQ-026 Pointer wrap-around SHALL preserve FIFO order across any number of wraps.

Reset
REQ-027 When rst is high at a rising edge, wr_ptr, rd_ptr, count and drop_count SHALL become 0, and a push or pop in that cycle SHALL be ignored.
REQ-028 After reset, outputs SHALL be rd_valid=0, empty=1, full=0, count=0, drop_count=0 and rd_*=0; storage array contents need not be cleared.
REQ-029 A reset asserted mid-operation SHALL discard all stored entries within one cycle.

Configuration
REQ-030 When macro TRACE_NOP_FILTER_EN is defined, accept SHALL be 0 for records with trace_instr==32'h00000013, so these NOPs are neither stored nor counted as drops.
REQ-031 When TRACE_NOP_FILTER_EN is undefined, accept SHALL be constantly 1, and the filter logic SHALL be absent.

Verification
REQ-032 Reset test: hold rst=1 for 2 cycles with trace_valid=1, then release -> count=0, empty=1, rd_valid=0, drop_count=0.
REQ-033 Single record test: push pc=0x4, instr=0x00100093, result=0x1 at edge N, with rd_ready=0 -> rd_valid=1 and rd_pc=0x4 in the cycle after N, and count=1.
REQ-034 Fill and overflow test: with DEPTH=16, push 20 records with pc=0,4,...,76 and rd_ready=0 -> full=1, count=16, drop_count=4; draining yields pc 0..60 in order.
REQ-035 Full simultaneous test: with the buffer full, set trace_valid=1 and rd_ready=1 for 8 cycles -> count stays 16, drop_count is unchanged, and output order is preserved across the pointer wrap.
REQ-036 Freeze test: with freeze=1, present 5 records -> count and drop_count are unchanged, while pops still drain stored entries.
REQ-037 Filter test: with TRACE_NOP_FILTER_EN defined, push instr 0x13, 0x00200113, 0x13 -> count=1 and rd_instr=0x00200113; with the macro undefined -> count=3.
